// File: rtl/muldiv_unit.sv
// Iterative RISC-V M-extension multiply/divide unit: radix-2 shift/add multiply and
// restoring divide, one bit per cycle, with valid/ready handshakes on both sides.
module muldiv_unit #(
    parameter int XLEN    = 64,
    parameter int WORD_EN = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [2:0]      op_i,
    input  logic            word_i,
    input  logic [XLEN-1:0] src1_i,
    input  logic [XLEN-1:0] src2_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [XLEN-1:0] res_o,
    output logic [1:0]      state_o
);

    // Handshake: a transfer happens on a rising edge where valid and ready are both
    // high. in_ready_o and out_valid_o come straight from the state register, so
    // neither ready nor valid ever depends combinationally on the other side.

    localparam int CW      = $clog2(XLEN);
    localparam int DW      = 2 * XLEN;
    localparam int WSHIFT  = XLEN - 32;
    localparam bit WORD_OK = (XLEN == 64) && (WORD_EN != 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    function automatic logic [XLEN-1:0] ext32(input logic [31:0] v, input logic sgn);
        logic [XLEN-1:0] r;
        r       = (sgn && v[31]) ? '1 : '0;
        r[31:0] = v;
        return r;
    endfunction

    logic            accept;
    logic            word_mode, is_div, sgn_a, sgn_b, neg_a, neg_b;
    logic            div_zero, div_ovf, special;
    logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag, dvd_init, min_ext;
    logic [XLEN-1:0] special_raw, special_res;

    logic [2:0]      op_q;
    logic            word_q, neg_q_q, neg_r_q;
    logic [CW-1:0]   cnt_q;
    logic [DW-1:0]   acc_q, mcand_q, acc_next, prod_s;
    logic [XLEN-1:0] opb_q, res_q;
    logic [XLEN:0]   rem_sh, trial;
    logic [XLEN-1:0] quo_s, rem_s, hi_word, final_raw, final_res;

    assign accept = in_valid_i && (state_q == IDLE) && !flush_i;

    // Operand preparation: extend, take magnitudes, and spot the no-iteration cases.
    always_comb begin
        word_mode = WORD_OK && word_i;
        is_div    = op_i[2];
        sgn_a     = (op_i == 3'd1) || (op_i == 3'd2) || (op_i == 3'd4) || (op_i == 3'd6);
        sgn_b     = (op_i == 3'd1) || (op_i == 3'd4) || (op_i == 3'd6);
        a_ext     = word_mode ? ext32(src1_i[31:0], sgn_a) : src1_i;
        b_ext     = word_mode ? ext32(src2_i[31:0], sgn_b) : src2_i;
        neg_a     = sgn_a && a_ext[XLEN-1];
        neg_b     = sgn_b && b_ext[XLEN-1];
        a_mag     = neg_a ? -a_ext : a_ext;
        b_mag     = neg_b ? -b_ext : b_ext;
        dvd_init  = word_mode ? (a_mag << WSHIFT) : a_mag;
        min_ext   = word_mode ? ext32(32'h8000_0000, 1'b1) : {1'b1, {(XLEN-1){1'b0}}};
        div_zero  = is_div && (b_ext == '0);
        div_ovf   = is_div && !op_i[0] && (a_ext == min_ext) && (b_ext == '1);
        special   = div_zero || div_ovf;
        special_raw = '0;
        if (div_zero) begin
            special_raw = op_i[1] ? a_ext : '1;
        end else if (div_ovf) begin
            special_raw = op_i[1] ? '0 : a_ext;
        end
        special_res = word_mode ? ext32(special_raw[31:0], 1'b1) : special_raw;
    end

    // One iteration: acc holds {remainder, quotient} when dividing, the product otherwise.
    always_comb begin
        rem_sh = acc_q[DW-1:XLEN-1];
        trial  = rem_sh - {1'b0, opb_q};
        if (op_q[2]) begin
            acc_next = trial[XLEN] ? {acc_q[DW-2:0], 1'b0}
                                   : {trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        end else begin
            acc_next = acc_q + (opb_q[0] ? mcand_q : '0);
        end
    end

    always_comb begin
        prod_s        = neg_q_q ? -acc_next : acc_next;
        quo_s         = neg_q_q ? -acc_next[XLEN-1:0] : acc_next[XLEN-1:0];
        rem_s         = neg_r_q ? -acc_next[DW-1:XLEN] : acc_next[DW-1:XLEN];
        hi_word       = '0;
        hi_word[31:0] = prod_s[63:32];
        final_raw     = '0;
        if (op_q[2]) begin
            final_raw = op_q[1] ? rem_s : quo_s;
        end else if (op_q[1:0] == 2'd0) begin
            final_raw = prod_s[XLEN-1:0];
        end else begin
            final_raw = word_q ? hi_word : prod_s[DW-1:XLEN];
        end
        final_res = word_q ? ext32(final_raw[31:0], 1'b1) : final_raw;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = special ? DONE : BUSY;
            BUSY: if (cnt_q == '0) state_d = DONE;
            DONE: if (out_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (flush_i) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q    <= '0;
            word_q  <= 1'b0;
            neg_q_q <= 1'b0;
            neg_r_q <= 1'b0;
            cnt_q   <= '0;
            acc_q   <= '0;
            mcand_q <= '0;
            opb_q   <= '0;
            res_q   <= '0;
        end else if (accept) begin
            op_q    <= op_i;
            word_q  <= word_mode;
            neg_q_q <= neg_a ^ neg_b;
            neg_r_q <= neg_a;
            cnt_q   <= word_mode ? CW'(31) : CW'(XLEN - 1);
            acc_q   <= is_div ? {{XLEN{1'b0}}, dvd_init} : '0;
            mcand_q <= {{XLEN{1'b0}}, a_mag};
            opb_q   <= b_mag;
            if (special) begin
                res_q <= special_res;
            end
        end else if (state_q == BUSY && !flush_i) begin
            acc_q   <= acc_next;
            mcand_q <= mcand_q << 1;
            opb_q   <= op_q[2] ? opb_q : (opb_q >> 1);
            cnt_q   <= cnt_q - CW'(1);
            if (cnt_q == '0) begin
                res_q <= final_res;
            end
        end
    end

    assign in_ready_o  = (state_q == IDLE);
    assign out_valid_o = (state_q == DONE);
    assign res_o       = res_q;
    assign state_o     = state_q;

endmodule
